mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu.sv | 137 +++++++++++++
 tb/tb_mdu.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: operation codes, FSM state encoding
// and default latencies used by the execute-stage MDU.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, models mult/div latency with a down-counter
// and commits the behaviourally computed result when the counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] md_out
);

    mdu_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    md_op_e      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] dvd, dvs, quo, rem, res_hi, res_lo;
    logic        div_signed, div_zero;

    // One 64x64 multiplier serves both flavours: the low 64 bits of the product
    // of sign- or zero-extended operands are the signed or unsigned result.
    always_comb begin
        mul_a = (op_q == MD_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_b = (op_q == MD_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = mul_a * mul_b;

        // Signed divide runs on magnitudes, so INT_MIN / -1 wraps to INT_MIN
        // with remainder 0 instead of overflowing.
        div_signed = (op_q == MD_DIV);
        div_zero   = (b_q == '0);
        dvd = (div_signed && a_q[31]) ? -a_q : a_q;
        dvs = (div_signed && b_q[31]) ? -b_q : b_q;
        if (div_zero) begin
            dvs = 32'd1;
        end
        quo = dvd / dvs;
        rem = dvd % dvs;
        if (div_signed && (a_q[31] ^ b_q[31])) begin
            quo = -quo;
        end
        if (div_signed && a_q[31]) begin
            rem = -rem;
        end

        if ((op_q == MD_MULT) || (op_q == MD_MULTU)) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && is_muldiv(md_op)) begin
                    op_d    = md_op_e'(md_op);
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = ((md_op == MD_MULT) || (md_op == MD_MULTU))
                              ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
                    state_d = ST_RUN;
                end else if (md_op == MD_MTHI) begin
                    hi_d = rs_val;
                end else if (md_op == MD_MTLO) begin
                    lo_d = rs_val;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!(((op_q == MD_DIV) || (op_q == MD_DIVU)) && div_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    always_comb begin
        md_out = '0;
        if (md_op == MD_MFHI) begin
            md_out = hi_q;
        end else if (md_op == MD_MFLO) begin
            md_out = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Randomised and directed bench for mdu against an arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] md_out;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .start  (start),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result using 64-bit integer arithmetic; returns 0 when HI/LO stay put.
    function automatic logic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        h = '0;
        l = '0;
        case (op)
            MD_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; return 1'b1; end
            MD_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; return 1'b1; end
            MD_DIV: begin
                if (b == 0) return 1'b0;
                q = sa / sb; r = sa % sb;
                p = q; l = p[31:0];
                p = r; h = p[31:0];
                return 1'b1;
            end
            MD_DIVU: begin
                if (b == 0) return 1'b0;
                q = ua / ub; r = ua % ub;
                p = q; l = p[31:0];
                p = r; h = p[31:0];
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    // Issue one mult/div, optionally injecting a stray MULT 3x4 start on busy cycle 'inject'.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles, input int inject);
        logic [31:0] eh, el;
        int n;
        md_op = op; start = 1'b1; rs_val = a; rt_val = b;
        tick();
        start = 1'b0; md_op = MD_MFHI; rs_val = $urandom; rt_val = $urandom;
        #1;
        check({tag, "_mdout_busy"}, md_out, hi_m);
        md_op = MD_NONE;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == inject) begin
                md_op = MD_MULT; start = 1'b1; rs_val = 32'd3; rt_val = 32'd4;
            end
            tick();
            start = 1'b0; md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        if (ref_md(op, a, b, eh, el)) begin
            hi_m = eh;
            lo_m = el;
        end
        check({tag, "_hi"}, hi_out, hi_m);
        check({tag, "_lo"}, lo_out, lo_m);
        md_op = MD_MFLO;
        #1;
        check({tag, "_mflo"}, md_out, lo_m);
        md_op = MD_NONE;
    endtask

    task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] v);
        md_op = op; rs_val = v;
        tick();
        md_op = MD_NONE; rs_val = $urandom;
        if (op == MD_MTHI) hi_m = v; else lo_m = v;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi_out, hi_m);
        check({tag, "_lo"}, lo_out, lo_m);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int unsigned sel;
        n_checks = 0; n_errors = 0;
        hi_m = '0; lo_m = '0;
        reset = 1'b1; md_op = MD_NONE; start = 1'b0; rs_val = '0; rt_val = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        md_op = MD_MFHI; #1;
        check("rst_mfhi", md_out, 32'd0);
        md_op = MD_NONE; #1;
        check("none_mdout", md_out, 32'd0);

        run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 5, -1);
        check("mult_hi_const", hi_out, 32'hFFFFFFFF);
        check("mult_lo_const", lo_out, 32'hFFFFFFFE);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, -1);
        check("multu_hi_const", hi_out, 32'h00000001);
        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, -1);
        check("div_lo_const", lo_out, 32'hFFFFFFFD);
        check("div_hi_const", hi_out, 32'hFFFFFFFF);
        run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 10, -1);
        check("divu_lo_const", lo_out, 32'h7FFFFFFC);
        check("divu_hi_const", hi_out, 32'h00000001);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, -1);
        check("div_ovf_lo_const", lo_out, 32'h80000000);

        move_to("mthi", MD_MTHI, 32'h12345678);
        move_to("mtlo", MD_MTLO, 32'h0BADF00D);
        run_op("div0", MD_DIV, 32'h00000064, 32'd0, 10, -1);
        check("div0_hi_const", hi_out, 32'h12345678);
        run_op("divu0", MD_DIVU, 32'h00000064, 32'd0, 10, -1);

        run_op("div_stray", MD_DIV, 32'd100, 32'd7, 10, 2);
        check("div_stray_lo_const", lo_out, 32'd14);
        check("div_stray_hi_const", hi_out, 32'd2);

        // Reset during the third busy cycle of a MULT must abort it cleanly.
        md_op = MD_MULT; start = 1'b1; rs_val = 32'h00010001; rt_val = 32'h00010001;
        tick();
        start = 1'b0; md_op = MD_NONE;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        repeat (8) tick();
        check("abort_late_busy", 32'(busy), 32'd0);
        check("abort_late_hi", hi_out, 32'd0);
        check("abort_late_lo", lo_out, 32'd0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 17));
                default: b = $urandom;
            endcase
            case (sel)
                0: op = MD_MULT;
                1: op = MD_MULTU;
                2: op = MD_DIV;
                3: op = MD_DIVU;
                4: op = MD_MTHI;
                default: op = MD_MTLO;
            endcase
            if (op == MD_MTHI || op == MD_MTLO)
                move_to("rnd_mt", op, a);
            else
                run_op("rnd", op, a, b, (op == MD_MULT || op == MD_MULTU) ? 5 : 10, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
